// File: rtl/firebird7_in_gate2_sri_pkg.sv
// Shared types for the sri reset-request sequencer: FSM state encoding and
// the two-bit status word returned through the TDR capture path.
package firebird7_in_gate2_sri_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ASSERT  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } sri_state_e;

  localparam logic [1:0] STATUS_IDLE = 2'b00;
  localparam logic [1:0] STATUS_BUSY = 2'b01;
  localparam logic [1:0] STATUS_DONE = 2'b10;
  localparam logic [1:0] STATUS_ERR  = 2'b11;

endpackage

// File: rtl/firebird7_in_gate2_tessent_sri_seq.sv
// Sequencer that turns a 1->0 edge on the sri TDR bit into a handshaked
// reset request. Define FIREBIRD7_SRI_TIMEOUT_EN to bound the ack waits.
module firebird7_in_gate2_tessent_sri_seq
  import firebird7_in_gate2_sri_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       ijtag_tck,
  input  logic       ijtag_reset,
  input  logic       sri_ctrl_in,
  input  logic       sri_ack,
  output logic       sri_rst_req,
  output logic       sri_busy,
  output logic       sri_done,
  output logic       sri_err,
  output logic [1:0] sri_status
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`ifdef FIREBIRD7_SRI_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  sri_state_e       state_q, state_d;
  logic             ctrl_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_req_q, rst_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       status_q, status_d;

  // Next-state/counter logic, then output decode of the next state so the
  // registered outputs track the state register cycle for cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q && !sri_ctrl_in) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (sri_ack) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
`ifdef FIREBIRD7_SRI_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        else begin
          state_d = ST_ASSERT;
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (!sri_ack) begin
          state_d = ST_DONE;
        end
`ifdef FIREBIRD7_SRI_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        else begin
          state_d = ST_RELEASE;
        end
`endif
      end
      ST_DONE: begin
        if (sri_ctrl_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERR: begin
        if (sri_ctrl_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    rst_req_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    status_d  = STATUS_IDLE;
    case (state_d)
      ST_IDLE: begin
        status_d = STATUS_IDLE;
      end
      ST_ASSERT, ST_HOLD: begin
        rst_req_d = 1'b1;
        busy_d    = 1'b1;
        status_d  = STATUS_BUSY;
      end
      ST_RELEASE: begin
        busy_d   = 1'b1;
        status_d = STATUS_BUSY;
      end
      ST_DONE: begin
        done_d   = 1'b1;
        status_d = STATUS_DONE;
      end
      ST_ERR: begin
`ifdef FIREBIRD7_SRI_TIMEOUT_EN
        err_d = 1'b1;
`endif
        status_d = STATUS_ERR;
      end
      default: begin
        status_d = STATUS_IDLE;
      end
    endcase
  end

  // State, edge-detect copy, shared counter and registered outputs.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 1'b1;
      cnt_q     <= CNT_ZERO;
      rst_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      status_q  <= STATUS_IDLE;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= sri_ctrl_in;
      cnt_q     <= cnt_d;
      rst_req_q <= rst_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      status_q  <= status_d;
    end
  end

  assign sri_rst_req = rst_req_q;
  assign sri_busy    = busy_q;
  assign sri_done    = done_q;
  assign sri_err     = err_q;
  assign sri_status  = status_q;

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_sri_seq.sv
// Scoreboard bench for the sri sequencer: each cycle's expected output word
// is queued with the stimulus and compared one edge later.
module tb_firebird7_in_gate2_tessent_sri_seq;

  logic       ijtag_tck = 1'b0;
  logic       ijtag_reset;
  logic       sri_ctrl_in;
  logic       sri_ack;
  logic       sri_rst_req;
  logic       sri_busy;
  logic       sri_done;
  logic       sri_err;
  logic [1:0] sri_status;

  int total = 0;
  int bad   = 0;

  // {rst_req, busy, done, err, status}
  localparam logic [5:0] E_IDLE = 6'b0_0_0_0_00;
  localparam logic [5:0] E_RST  = 6'b1_1_0_0_01;
  localparam logic [5:0] E_REL  = 6'b0_1_0_0_01;
  localparam logic [5:0] E_DONE = 6'b0_0_1_0_10;
  localparam logic [5:0] E_ERR  = 6'b0_0_0_1_11;

  logic [5:0] exp_q[$];

  firebird7_in_gate2_tessent_sri_seq #(
    .CNT_W(8), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(200)
  ) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .sri_ctrl_in (sri_ctrl_in),
    .sri_ack     (sri_ack),
    .sri_rst_req (sri_rst_req),
    .sri_busy    (sri_busy),
    .sri_done    (sri_done),
    .sri_err     (sri_err),
    .sri_status  (sri_status)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  task automatic push_exp(input logic [5:0] e);
    exp_q.push_back(e);
  endtask

  // One rising edge, then pop the oldest expectation and compare.
  task automatic tick(input string nm);
    logic [5:0] got;
    logic [5:0] want;
    @(posedge ijtag_tck);
    #1;
    got  = {sri_rst_req, sri_busy, sri_done, sri_err, sri_status};
    want = exp_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
    end
  endtask

  task automatic test_reset();
    ijtag_reset = 1'b1;
    sri_ctrl_in = 1'b1;
    sri_ack     = 1'b0;
    push_exp(E_IDLE); tick("reset_a");
    push_exp(E_IDLE); tick("reset_b");
    ijtag_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(E_IDLE); tick("idle_no_req");
    end
  endtask

  task automatic test_basic();
    sri_ctrl_in = 1'b0;
    push_exp(E_RST); tick("assert_entry");
    push_exp(E_RST); tick("assert_wait1");
    push_exp(E_RST); tick("assert_wait2");
    sri_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_exp(E_RST); tick("hold");
    end
    push_exp(E_REL); tick("release_entry");
    push_exp(E_REL); tick("release_wait");
    sri_ack = 1'b0;
    push_exp(E_DONE); tick("done_entry");
    push_exp(E_DONE); tick("done_stay");
  endtask

  task automatic test_done_exit();
    sri_ctrl_in = 1'b1;
    push_exp(E_IDLE); tick("done_to_idle");
    sri_ctrl_in = 1'b0;
    push_exp(E_RST); tick("second_seq");
  endtask

  task automatic test_reset_in_hold();
    sri_ack = 1'b1;
    push_exp(E_RST); tick("hold_pre_rst_a");
    push_exp(E_RST); tick("hold_pre_rst_b");
    ijtag_reset = 1'b1;
    push_exp(E_IDLE); tick("rst_mid_hold");
    ijtag_reset = 1'b0;
    sri_ack     = 1'b0;
    push_exp(E_RST); tick("restart_after_rst");
    ijtag_reset = 1'b1;
    sri_ctrl_in = 1'b1;
    push_exp(E_IDLE); tick("reset_again");
    ijtag_reset = 1'b0;
  endtask

  task automatic test_ack_early();
    sri_ack = 1'b1;
    push_exp(E_IDLE); tick("idle_ack_high");
    sri_ctrl_in = 1'b0;
    push_exp(E_RST); tick("early_assert");
    for (int i = 0; i < 16; i++) begin
      if (i == 4) sri_ctrl_in = 1'b1;
      if (i == 8) sri_ack = 1'b0;
      push_exp(E_RST); tick("early_hold");
    end
    push_exp(E_REL); tick("early_release");
    push_exp(E_DONE); tick("early_done");
    push_exp(E_IDLE); tick("early_idle");
  endtask

`ifdef FIREBIRD7_SRI_TIMEOUT_EN
  task automatic test_timeout();
    sri_ack     = 1'b0;
    sri_ctrl_in = 1'b0;
    push_exp(E_RST); tick("to_assert_entry");
    for (int i = 1; i < 200; i++) begin
      push_exp(E_RST); tick("to_assert_wait");
    end
    push_exp(E_ERR); tick("to_err_entry");
    push_exp(E_ERR); tick("to_err_stay");
    sri_ctrl_in = 1'b1;
    push_exp(E_IDLE); tick("err_to_idle");
  endtask
`else
  task automatic test_timeout();
    sri_ack     = 1'b0;
    sri_ctrl_in = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      push_exp(E_RST); tick("no_to_assert");
    end
    ijtag_reset = 1'b1;
    sri_ctrl_in = 1'b1;
    push_exp(E_IDLE); tick("no_to_reset");
    ijtag_reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_done_exit();
    test_reset_in_hold();
    test_ack_early();
    test_timeout();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate2_tessent_sri_seq.md
FIREBIRD7_IN_GATE2_TESSENT_SRI_SEQ -- requirements
Module: firebird7_in_gate2_tessent_sri_seq

Interface
REQ-001 Parameter CNT_W, default 8: width of the single internal counter.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles sri_rst_req stays high after ack; legal range 1..2^CNT_W-1.
REQ-003 Parameter TIMEOUT_CYCLES, default 200: maximum cycles to wait for an ack edge; legal range 1..2^CNT_W-1.
REQ-004 ijtag_tck  input  1  sole clock; all state changes on its rising edge.
REQ-005 ijtag_reset  input  1  synchronous, active-high reset.
REQ-006 sri_ctrl_in  input  1  request bit from the upstream sri TDR data-out; 1 = no request (TDR reset value), 0 = request.
REQ-007 sri_ack  input  1  acknowledge from the functional reset logic; level signal.
REQ-008 sri_rst_req  output  1  reset request to the functional domain.
REQ-009 sri_busy  output  1  high in ASSERT, HOLD or RELEASE.
REQ-010 sri_done  output  1  high in DONE.
REQ-011 sri_err  output  1  high in ERR.
REQ-012 sri_status  output  2  TDR capture value: 00 idle, 01 busy, 10 done, 11 err.

Function
REQ-013 FSM states SHALL be IDLE, ASSERT, HOLD, RELEASE, DONE, ERR; all outputs are Moore decodes of the state register.
REQ-014 A registered copy ctrl_q of sri_ctrl_in SHALL detect a request as ctrl_q==1 and sri_ctrl_in==0.
REQ-015 IDLE -> ASSERT on a detected request; sri_rst_req SHALL be high from the next cycle (1-cycle latency).
REQ-016 ASSERT: sri_rst_req=1; on sri_ack==1 -> HOLD, with the counter loaded to HOLD_CYCLES-1.
REQ-017 HOLD: sri_rst_req=1; the counter decrements each cycle; at 0 -> RELEASE; HOLD SHALL last exactly HOLD_CYCLES cycles.
REQ-018 HOLD SHALL ignore sri_ack.
REQ-019 RELEASE: sri_rst_req=0; on sri_ack==0 -> DONE.
REQ-020 DONE: stays in DONE until sri_ctrl_in==1, then -> IDLE.
REQ-021 ERR: sri_rst_req=0; stays in ERR until sri_ctrl_in==1, then -> IDLE.
REQ-022 Withdrawing the request (sri_ctrl_in back to 1) during ASSERT/HOLD/RELEASE SHALL NOT abort the sequence.
REQ-023 A request detected while in DONE or ERR SHALL be ignored; only a fresh 1->0 edge from IDLE starts a sequence.
REQ-024 If sri_ack is already 1 on entry to ASSERT, the FSM SHALL go to HOLD on the next edge.
REQ-025 The counter SHALL NOT wrap; all compares are unsigned at CNT_W bits.

Reset
REQ-026 While ijtag_reset=1 at a rising edge: state=IDLE, ctrl_q=1, counter=0.
REQ-027 Outputs after that edge: sri_rst_req=0, sri_busy=0, sri_done=0, sri_err=0, sri_status=00.
REQ-028 Reset mid-sequence SHALL drop sri_rst_req on the same edge.
REQ-029 sri_ctrl_in==0 in the first cycle after reset SHALL count as a request, because ctrl_q resets to 1.

Configuration
REQ-030 With FIREBIRD7_SRI_TIMEOUT_EN defined: the counter clears on entry to ASSERT or RELEASE and increments each cycle there; reaching TIMEOUT_CYCLES-1 without the awaited ack level -> ERR.
REQ-031 Without FIREBIRD7_SRI_TIMEOUT_EN: ASSERT/RELEASE wait indefinitely, ERR is unreachable, sri_err is constant 0, and status 11 never occurs.

Structure
REQ-032 Package firebird7_in_gate2_sri_pkg SHALL hold the state enum and the four sri_status encoding constants.
REQ-033 No sub-module; one counter shared between hold and timeout use.

Verification
REQ-034 Reset, then sri_ctrl_in 1->0 at cycle 5, sri_ack=1 three cycles after sri_rst_req rises, HOLD_CYCLES=16 -> sri_rst_req high for 3+16 cycles, then low; ack dropped -> sri_status=10.
REQ-035 In DONE, set sri_ctrl_in=1 -> IDLE and status 00 the next cycle; new 1->0 edge -> new sequence.
REQ-036 Timeout enabled, TIMEOUT_CYCLES=200, sri_ack held 0 -> ERR exactly 200 cycles after ASSERT entry, sri_err=1, status 11, sri_rst_req=0.
REQ-037 Timeout disabled, sri_ack held 0 for 1000 cycles -> stays in ASSERT, sri_err=0.
REQ-038 ijtag_reset pulsed during HOLD -> sri_rst_req=0 after that edge; with sri_ctrl_in held 0, a new sequence starts on release.
REQ-039 sri_ack=1 before the request -> ASSERT lasts one cycle; sri_ctrl_in toggled to 1 during HOLD -> sequence still completes.
